// File: rtl/ros2_udp_pkg.sv
// Shared definitions for the ros2_ether UDP transmit-buffer path:
// txbuf word layout and the scheduler state encoding.
package ros2_udp_pkg;

    localparam int unsigned TXW_DST_IP  = 0;
    localparam int unsigned TXW_PORTS   = 1;
    localparam int unsigned TXW_LEN     = 2;
    localparam int unsigned TXW_PAYLOAD = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_SEND  = 2'd2,
        ST_WAIT  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/udp_rr_arbiter.sv
// Round-robin pick of the first requesting channel at or after the pointer.
// The pick is combinational; the pointer only moves when the owner asks it to.
module udp_rr_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              adv,
    input  logic [CH_W-1:0]   adv_ch,
    output logic              grant_vld_c,
    output logic [CH_W-1:0]   grant_ch_c
);

    logic [CH_W-1:0] ptr;
    logic            lo_vld;
    logic            hi_vld;
    logic [CH_W-1:0] lo_ch;
    logic [CH_W-1:0] hi_ch;

    // Lowest requester overall, and lowest requester at or above the pointer.
    always_comb begin
        lo_vld = 1'b0;
        hi_vld = 1'b0;
        lo_ch  = '0;
        hi_ch  = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_vld = 1'b1;
                lo_ch  = CH_W'(i);
                if (32'(i) >= 32'(ptr)) begin
                    hi_vld = 1'b1;
                    hi_ch  = CH_W'(i);
                end
            end
        end
        grant_vld_c = lo_vld;
        grant_ch_c  = hi_vld ? hi_ch : lo_ch;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (32'(adv_ch) >= NUM_CH - 1) ? '0 : adv_ch + CH_W'(1);
        end
    end

endmodule

// File: rtl/udp_txbuf_sched.sv
// Multi-channel UDP transmit-buffer scheduler: per-channel descriptors, on-demand
// and periodic queueing, round-robin service over the txbuf rel/grant handshake.
module udp_txbuf_sched
    import ros2_udp_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned TXBUF_AWIDTH  = 6,
    parameter int unsigned PAYLOAD_WORDS = 16,
    parameter int unsigned PERIOD_WIDTH  = 28,
    parameter int unsigned GRANT_TIMEOUT = 1000000,
    localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [CH_W-1:0]                wr_ch,
    input  logic [TXBUF_AWIDTH-1:0]        wr_addr,
    input  logic [31:0]                    wr_data,
    output logic                           wr_err,
    input  logic [NUM_CH-1:0]              send_req,
    input  logic [NUM_CH*PERIOD_WIDTH-1:0] period,
    output logic                           txbuf_rel,
    input  logic                           txbuf_grant,
    input  logic [TXBUF_AWIDTH-1:0]        txbuf_addr,
    output logic [31:0]                    txbuf_rdata,
    output logic                           busy,
    output logic [CH_W-1:0]                active_ch,
    output logic                           tx_done,
    output logic                           tx_timeout,
    output logic                           len_err
);

    localparam int unsigned DEPTH   = TXW_PAYLOAD + PAYLOAD_WORDS;
    localparam int unsigned DEPTH_W = $clog2(DEPTH);
    localparam int unsigned TO_W    = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
    localparam int unsigned MAX_LEN = PAYLOAD_WORDS * 4;

    logic [31:0]             mem [NUM_CH][DEPTH];
    logic [PERIOD_WIDTH-1:0] per_cnt [NUM_CH];
    logic [NUM_CH-1:0]       pending;
    logic [NUM_CH-1:0]       tick_c, per_zero_c, set_c, clr_c;
    logic [TO_W-1:0]         to_cnt, to_cnt_d;
    tx_state_t               state, state_d;
    logic                    sel, adv, arb_vld;
    logic [CH_W-1:0]         arb_ch;
    logic                    rel_d, busy_d, done_d, tmo_d, lerr_d;
    logic                    wr_drop_c, len_bad_c;
    logic [31:0]             len_word_c;

    udp_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (pending),
        .adv         (adv),
        .adv_ch      (active_ch),
        .grant_vld_c (arb_vld),
        .grant_ch_c  (arb_ch)
    );

    // Descriptor storage; the channel being served is locked against writes.
    assign wr_drop_c = (32'(wr_addr) >= DEPTH) || (32'(wr_ch) >= NUM_CH) ||
                       (busy && (wr_ch == active_ch));

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err <= 1'b0;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                for (int a = 0; a < int'(DEPTH); a++) begin
                    mem[c][a] <= '0;
                end
            end
        end else begin
            wr_err <= wr_en && wr_drop_c;
            if (wr_en && !wr_drop_c) begin
                mem[wr_ch][wr_addr[DEPTH_W-1:0]] <= wr_data;
            end
        end
    end

    assign txbuf_rdata = (32'(txbuf_addr) < DEPTH) ? mem[active_ch][txbuf_addr[DEPTH_W-1:0]] : '0;

    assign len_word_c = mem[active_ch][DEPTH_W'(TXW_LEN)];
    assign len_bad_c  = (len_word_c == '0) || (len_word_c > 32'(MAX_LEN));

    // Pending sources; a set in the same cycle as the selecting clear wins.
    always_comb begin
        logic [PERIOD_WIDTH-1:0] per;
        per        = '0;
        tick_c     = '0;
        per_zero_c = '0;
        set_c      = '0;
        clr_c      = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            per           = period[i*PERIOD_WIDTH +: PERIOD_WIDTH];
            per_zero_c[i] = (per == '0);
            tick_c[i]     = (per != '0) && (per_cnt[i] >= per - PERIOD_WIDTH'(1));
            set_c[i]      = (send_req[i] && !((state != ST_IDLE) && (active_ch == CH_W'(i))))
                            || tick_c[i];
            clr_c[i]      = sel && (arb_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                per_cnt[i] <= '0;
            end
        end else begin
            pending <= set_c | (pending & ~clr_c);
            for (int i = 0; i < int'(NUM_CH); i++) begin
                per_cnt[i] <= (per_zero_c[i] || tick_c[i]) ? '0 : per_cnt[i] + PERIOD_WIDTH'(1);
            end
        end
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        state_d  = state;
        to_cnt_d = '0;
        sel      = 1'b0;
        adv      = 1'b0;
        rel_d    = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        tmo_d    = 1'b0;
        lerr_d   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_vld) begin
                    sel     = 1'b1;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (len_bad_c) begin
                    lerr_d  = 1'b1;
                    adv     = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    rel_d   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                busy_d  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (txbuf_grant) begin
                    done_d  = 1'b1;
                    adv     = 1'b1;
                    state_d = ST_IDLE;
                end else if (to_cnt == TO_W'(GRANT_TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    adv     = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    busy_d   = 1'b1;
                    to_cnt_d = to_cnt + TO_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            to_cnt     <= '0;
            active_ch  <= '0;
            txbuf_rel  <= 1'b0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            tx_timeout <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            state      <= state_d;
            to_cnt     <= to_cnt_d;
            txbuf_rel  <= rel_d;
            busy       <= busy_d;
            tx_done    <= done_d;
            tx_timeout <= tmo_d;
            len_err    <= lerr_d;
            if (sel) begin
                active_ch <= arb_ch;
            end
        end
    end

endmodule

// File: tb/tb_udp_txbuf_sched.sv
// Directed bench for udp_txbuf_sched: single send, round robin, periodic,
// length errors, grant timeout with write lock, and reset during WAIT.
module tb_udp_txbuf_sched;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned PERW   = 28;

    logic               clk = 1'b0;
    logic               rst;
    logic               wr_en;
    logic [1:0]         wr_ch;
    logic [5:0]         wr_addr;
    logic [31:0]        wr_data;
    logic               wr_err;
    logic [3:0]         send_req;
    logic [NUM_CH*PERW-1:0] period;
    logic               txbuf_rel;
    logic               txbuf_grant;
    logic [5:0]         txbuf_addr;
    logic [31:0]        txbuf_rdata;
    logic               busy;
    logic [1:0]         active_ch;
    logic               tx_done;
    logic               tx_timeout;
    logic               len_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    udp_txbuf_sched #(
        .NUM_CH        (4),
        .TXBUF_AWIDTH  (6),
        .PAYLOAD_WORDS (16),
        .PERIOD_WIDTH  (28),
        .GRANT_TIMEOUT (50)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_err      (wr_err),
        .send_req    (send_req),
        .period      (period),
        .txbuf_rel   (txbuf_rel),
        .txbuf_grant (txbuf_grant),
        .txbuf_addr  (txbuf_addr),
        .txbuf_rdata (txbuf_rdata),
        .busy        (busy),
        .active_ch   (active_ch),
        .tx_done     (tx_done),
        .tx_timeout  (tx_timeout),
        .len_err     (len_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log, sampled on the falling edge.
    int rel_cnt = 0, done_cnt = 0, tmo_cnt = 0, lerr_cnt = 0;
    int rel_ch[$];
    int rel_t[$];
    int tmo_t[$];
    always @(negedge clk) begin
        if (txbuf_rel) begin
            rel_cnt++;
            rel_ch.push_back(int'(active_ch));
            rel_t.push_back(cyc);
        end
        if (tx_done) done_cnt++;
        if (tx_timeout) begin
            tmo_cnt++;
            tmo_t.push_back(cyc);
        end
        if (len_err) lerr_cnt++;
    end

    // Stack model: grant grant_delay falling edges after each rel (0 = never).
    int grant_delay = 0;
    int gcnt = 0;
    logic force_grant = 1'b0;
    always @(negedge clk) begin
        txbuf_grant = 1'b0;
        if (gcnt != 0) begin
            gcnt--;
            if (gcnt == 0) txbuf_grant = 1'b1;
        end
        if (txbuf_rel && grant_delay != 0) gcnt = grant_delay;
        if (force_grant) txbuf_grant = 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int ch, input int addr, input logic [31:0] d, output logic err);
        @(negedge clk);
        wr_en = 1'b1; wr_ch = 2'(ch); wr_addr = 6'(addr); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        err = wr_err;
    endtask

    task automatic req(input logic [3:0] v);
        @(negedge clk);
        send_req = v;
        @(negedge clk);
        send_req = '0;
    endtask

    task automatic wait_busy(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (busy) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        checks++; if (txbuf_rel !== 1'b0) begin errors++; $display("FAIL reset_rel: got %0b want 0", txbuf_rel); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (active_ch !== 2'd0) begin errors++; $display("FAIL reset_active_ch: got %0d want 0", active_ch); end
        checks++; if ({tx_done, tx_timeout, len_err, wr_err} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {tx_done, tx_timeout, len_err, wr_err}); end
        txbuf_addr = 6'd0; #1;
        checks++; if (txbuf_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %0h want 0", txbuf_rdata); end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_single();
        logic e;
        bit ok, seen;
        int b, bd;
        logic [31:0] exp_w [6];
        exp_w[0] = 32'h0a01a8c0; exp_w[1] = 32'h045704d2; exp_w[2] = 32'd7;
        exp_w[3] = 32'h626f6f66; exp_w[4] = 32'h000a7261; exp_w[5] = 32'd0;
        for (int a = 0; a < 5; a++) wr(0, a, exp_w[a], e);
        grant_delay = 10;
        b = rel_cnt; bd = done_cnt;
        req(4'b0001);
        wait_busy(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_busy: got 0 want 1"); end
        for (int a = 0; a < 6; a++) begin
            txbuf_addr = 6'(a); #1;
            checks++; if (txbuf_rdata !== exp_w[a]) begin errors++; $display("FAIL single_rdata[%0d]: got %0h want %0h", a, txbuf_rdata, exp_w[a]); end
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (tx_done) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL single_done: got 0 want 1"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop: got %0b want 0", busy); end
        tick(2);
        checks++; if (rel_cnt - b != 1) begin errors++; $display("FAIL single_rel_count: got %0d want 1", rel_cnt - b); end
        checks++; if (done_cnt - bd != 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", done_cnt - bd); end
    endtask

    task automatic test_round_robin();
        logic e;
        int b;
        int exp_ch [5];
        exp_ch[0] = 0; exp_ch[1] = 1; exp_ch[2] = 3; exp_ch[3] = 0; exp_ch[4] = 3;
        rst = 1'b1; tick(2); rst = 1'b0;
        wr(0, 2, 32'd4, e); wr(1, 2, 32'd4, e); wr(3, 2, 32'd4, e);
        grant_delay = 1;
        b = rel_cnt;
        req(4'b1011);
        tick(30);
        checks++; if (rel_cnt - b != 3) begin errors++; $display("FAIL rr_count: got %0d want 3", rel_cnt - b); end
        if (rel_t.size() >= b + 2) begin
            checks++; if (rel_t[b+1] - rel_t[b] != 4) begin errors++; $display("FAIL rr_spacing: got %0d want 4", rel_t[b+1] - rel_t[b]); end
        end
        req(4'b1001);
        tick(20);
        checks++; if (rel_cnt - b != 5) begin errors++; $display("FAIL rr_count2: got %0d want 5", rel_cnt - b); end
        for (int k = 0; k < 5; k++) begin
            if (rel_ch.size() > b + k) begin
                checks++; if (rel_ch[b+k] != exp_ch[k]) begin errors++; $display("FAIL rr_order[%0d]: got ch%0d want ch%0d", k, rel_ch[b+k], exp_ch[k]); end
            end
        end
    endtask

    task automatic test_periodic();
        logic e;
        int b, b2, d;
        wr(2, 2, 32'd4, e);
        grant_delay = 1;
        b = rel_cnt;
        period[2*PERW +: PERW] = 28'd100;
        tick(420);
        checks++; if (rel_cnt - b != 4) begin errors++; $display("FAIL periodic_count: got %0d want 4", rel_cnt - b); end
        for (int k = 1; k < 4; k++) begin
            if (rel_t.size() > b + k) begin
                d = rel_t[b+k] - rel_t[b+k-1];
                checks++; if (d < 96 || d > 104 || rel_ch[b+k] != 2) begin errors++; $display("FAIL periodic_interval[%0d]: got %0d on ch%0d want 100 on ch2", k, d, rel_ch[b+k]); end
            end
        end
        period[2*PERW +: PERW] = 28'd0;
        b2 = rel_cnt;
        tick(250);
        checks++; if (rel_cnt != b2) begin errors++; $display("FAIL periodic_stop: got %0d sends want 0", rel_cnt - b2); end
    endtask

    task automatic test_len_err();
        logic e;
        int b, bl;
        logic [31:0] bad_len [2];
        bad_len[0] = 32'd0; bad_len[1] = 32'd65;
        grant_delay = 1;
        for (int k = 0; k < 2; k++) begin
            wr(1, 2, bad_len[k], e);
            b = rel_cnt; bl = lerr_cnt;
            req(4'b0110);
            tick(20);
            checks++; if (lerr_cnt - bl != 1) begin errors++; $display("FAIL len_err_pulse[%0d]: got %0d want 1", k, lerr_cnt - bl); end
            checks++; if (rel_cnt - b != 1) begin errors++; $display("FAIL len_err_rel[%0d]: got %0d want 1", k, rel_cnt - b); end
            if (rel_ch.size() > b) begin
                checks++; if (rel_ch[b] != 2) begin errors++; $display("FAIL len_err_next[%0d]: got ch%0d want ch2", k, rel_ch[b]); end
            end
        end
        wr(1, 2, 32'd64, e);
        b = rel_cnt; bl = lerr_cnt;
        req(4'b0010);
        tick(15);
        checks++; if (lerr_cnt != bl || rel_cnt - b != 1) begin errors++; $display("FAIL len_max_ok: got len_err=%0d rel=%0d want 0 and 1", lerr_cnt - bl, rel_cnt - b); end
    endtask

    task automatic test_timeout();
        logic e;
        bit ok, seen;
        int b, bt, bd;
        wr(0, 3, 32'h11223344, e);
        grant_delay = 0;
        b = rel_cnt; bt = tmo_cnt; bd = done_cnt;
        req(4'b0001);
        wait_busy(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_busy: got 0 want 1"); end
        wr(0, 3, 32'hdeadbeef, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL lock_wr_err: got %0b want 1", e); end
        txbuf_addr = 6'd3; #1;
        checks++; if (txbuf_rdata !== 32'h11223344) begin errors++; $display("FAIL lock_storage: got %0h want 11223344", txbuf_rdata); end
        wr(3, 18, 32'hcafef00d, e);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_last_addr: got %0b want 0", e); end
        wr(3, 19, 32'hcafef00d, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL wr_addr_range: got %0b want 1", e); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_still_busy: got %0b want 1", busy); end
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (tx_timeout) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL timeout_pulse: got 0 want 1"); end
        tick(2);
        checks++; if (tmo_cnt - bt != 1 || done_cnt != bd) begin errors++; $display("FAIL timeout_events: got tmo=%0d done=%0d want 1 and 0", tmo_cnt - bt, done_cnt - bd); end
        // rel is seen in SEND; WAIT starts one edge later, timeout 50 edges after that
        if (tmo_t.size() > bt && rel_t.size() > b) begin
            checks++; if (tmo_t[bt] - rel_t[b] != 51) begin errors++; $display("FAIL timeout_latency: got %0d want 51", tmo_t[bt] - rel_t[b]); end
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        int bd, bl, br;
        grant_delay = 0;
        req(4'b0001);
        wait_busy(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstwait_busy: got 0 want 1"); end
        tick(3);
        rst = 1'b1;
        tick(1);
        checks++; if ({txbuf_rel, busy, tx_done, tx_timeout, len_err, wr_err} !== 6'b0) begin errors++; $display("FAIL rstwait_outputs: got %b want 000000", {txbuf_rel, busy, tx_done, tx_timeout, len_err, wr_err}); end
        checks++; if (active_ch !== 2'd0) begin errors++; $display("FAIL rstwait_active_ch: got %0d want 0", active_ch); end
        txbuf_addr = 6'd3; #1;
        checks++; if (txbuf_rdata !== 32'd0) begin errors++; $display("FAIL rstwait_storage: got %0h want 0", txbuf_rdata); end
        rst = 1'b0;
        bd = done_cnt;
        force_grant = 1'b1;
        tick(2);
        force_grant = 1'b0;
        tick(3);
        checks++; if (done_cnt != bd || busy !== 1'b0) begin errors++; $display("FAIL rstwait_grant: got done=%0d busy=%0b want 0 and 0", done_cnt - bd, busy); end
        bl = lerr_cnt; br = rel_cnt;
        req(4'b0001);
        tick(10);
        checks++; if (lerr_cnt - bl != 1 || rel_cnt != br) begin errors++; $display("FAIL rstwait_cleared_len: got len_err=%0d rel=%0d want 1 and 0", lerr_cnt - bl, rel_cnt - br); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_addr = '0; wr_data = '0;
        send_req = '0; period = '0; txbuf_addr = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_periodic();
        test_len_err();
        test_timeout();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
